// File: rtl/ika2151_lfo_regctl.sv
// ika2151_lfo_regctl: host-bus register controller for the LFO (regs 0x01, 0x18, 0x19, 0x1B)
module ika2151_lfo_regctl #(
    parameter int BUSY_CYCLES = 64,
    parameter int UPD_CYCLES  = 2
) (
    input  logic       i_EMUCLK,
    input  logic       i_MRST,
    input  logic       i_phi1_NCEN_n,
    input  logic       i_CS_n,
    input  logic       i_WR_n,
    input  logic       i_A0,
    input  logic [7:0] i_D,
    output logic [7:0] o_TEST,
    output logic [7:0] o_LFRQ,
    output logic [6:0] o_AMD,
    output logic [6:0] o_PMD,
    output logic [1:0] o_W,
    output logic [1:0] o_CT,
    output logic       o_LFRQ_UPDATE_n,
    output logic       o_BUSY
);
    typedef enum logic [1:0] {IDLE, PEND, BUSY} state_t;
    state_t      state;
    logic        s;
    logic        a0_h;
    logic [7:0]  d_h;
    logic [2:0]  s_sy;
    logic        ev;
    logic        phi;
    logic        commit;
    logic [7:0]  addr;
    logic [7:0]  c_addr;
    logic [7:0]  c_data;
    logic [7:0]  bcnt;
    logic [3:0]  ucnt;
    assign s      = i_CS_n | i_WR_n;
    assign ev     = s_sy[1] & ~s_sy[2];
    assign phi    = ~i_phi1_NCEN_n;
    assign commit = (state == PEND) & phi;
    // hold bus lines while the strobe is low, then synchronise the strobe and keep one edge-detect stage
    always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
        if (i_MRST) begin
            a0_h <= 1'b0;
            d_h  <= 8'h00;
            s_sy <= 3'b111;
        end else begin
            if (!s) begin
                a0_h <= i_A0;
                d_h  <= i_D;
            end
            s_sy <= {s_sy[1:0], s};
        end
    end
    // address latch, commit buffer and IDLE/PEND/BUSY sequencing with the busy flag
    always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
        if (i_MRST) begin
            state  <= IDLE;
            addr   <= 8'h00;
            c_addr <= 8'h00;
            c_data <= 8'h00;
            bcnt   <= 8'h00;
            o_BUSY <= 1'b0;
        end else begin
            if (ev && !a0_h) addr <= d_h;
            case (state)
                IDLE: if (ev && a0_h) begin
                    c_addr <= addr;
                    c_data <= d_h;
                    state  <= PEND;
                end
                PEND: begin
                    o_BUSY <= 1'b1;
                    if (phi) begin
                        bcnt  <= BUSY_CYCLES[7:0];
                        state <= BUSY;
                    end
                end
                BUSY: if (phi) begin
                    bcnt <= bcnt - 8'd1;
                    if (bcnt == 8'd1) begin
                        state  <= IDLE;
                        o_BUSY <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    // decode the buffered write into the static configuration registers on the commit edge
    always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
        if (i_MRST) begin
            o_TEST <= 8'h00;
            o_LFRQ <= 8'h00;
            o_AMD  <= 7'h00;
            o_PMD  <= 7'h00;
            o_W    <= 2'b00;
            o_CT   <= 2'b00;
        end else if (commit) begin
            case (c_addr)
                8'h01: o_TEST <= c_data;
                8'h18: o_LFRQ <= c_data;
                8'h19: if (c_data[7]) o_PMD <= c_data[6:0]; else o_AMD <= c_data[6:0];
                8'h1B: begin
                    o_W  <= c_data[1:0];
                    o_CT <= c_data[7:6];
                end
                default: ;
            endcase
        end
    end
    // LFRQ reload strobe: held low for UPD_CYCLES phi1 enables, re-armed by another LFRQ commit
    always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
        if (i_MRST) begin
            o_LFRQ_UPDATE_n <= 1'b1;
            ucnt            <= 4'h0;
        end else if (commit && c_addr == 8'h18) begin
            o_LFRQ_UPDATE_n <= 1'b0;
            ucnt            <= UPD_CYCLES[3:0];
        end else if (!o_LFRQ_UPDATE_n && phi) begin
            ucnt <= ucnt - 4'd1;
            if (ucnt == 4'd1) o_LFRQ_UPDATE_n <= 1'b1;
        end
    end
endmodule
